// File: rtl/core_uart_tx_if.sv
// Byte push channel into core_uart_tx: valid/ready handshake with an 8-bit payload.
interface core_uart_tx_if;
    logic       wr_valid_i;
    logic [7:0] wr_data_i;
    logic       wr_ready_o;

    modport master (output wr_valid_i, output wr_data_i, input wr_ready_o);
    modport slave  (input wr_valid_i, input wr_data_i, output wr_ready_o);
endinterface

// File: rtl/core_uart_tx.sv
// core_uart_tx: 8N1 UART transmitter fed by a byte FIFO, frames sent back-to-back LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module core_uart_tx #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int UART_BAUD   = 115200,
    parameter int FIFO_DEPTH  = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    core_uart_tx_if.slave wr,
    output logic          txd_o,
    output logic          busy_o,
    output logic [AW:0]   fifo_cnt_o
);

    localparam int DIV = CLK_FREQ_HZ / UART_BAUD;
    localparam int BW  = $clog2(DIV);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    state_e        state_q,   state_d;
    logic [BW-1:0] baud_q,    baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q,   shift_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [AW:0]   cnt_q,     cnt_d;
    logic          txd_q,     txd_d;
    logic          busy_q,    busy_d;
    logic          ready_q,   ready_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic tick_s;
    logic push_s;
    logic pop_s;
    logic empty_s;

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    assign tick_s  = (baud_q == BW'(DIV - 1));
    assign empty_s = (cnt_q == (AW+1)'(0));
    // ready_q always equals "not full" for the current count, so a pop cannot open a slot early
    assign push_s  = wr.wr_valid_i && ready_q;

    // Frame sequencer: baud counter, bit index, shift register and pop decision
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop_s     = 1'b0;
        if ((state_q == ST_IDLE) || tick_s) begin
            baud_d = BW'(0);
        end else begin
            baud_d = baud_q + BW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s && !empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_START;
                end else if (tick_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (pop_s) begin
            shift_d = mem_q[rd_ptr_q];
        end else begin
            shift_d = shift_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the byte is captured together with the byte itself
    always_comb begin
        if (pop_s) begin
            parity_d = even_parity(mem_q[rd_ptr_q]);
        end else begin
            parity_d = parity_q;
        end
    end
`endif

    // FIFO pointer and occupancy update
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Outputs are decoded from next-state values so each one comes straight from a flop
    always_comb begin
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = parity_d;
`endif
            default:  txd_d = 1'b1;
        endcase
        busy_d  = (state_d != ST_IDLE) || (cnt_d != (AW+1)'(0));
        ready_d = (cnt_d != (AW+1)'(FIFO_DEPTH));
    end

    // FIFO storage; contents need no reset because pointers and count are cleared
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr.wr_data_i;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            baud_q    <= BW'(0);
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            wr_ptr_q  <= AW'(0);
            rd_ptr_q  <= AW'(0);
            cnt_q     <= (AW+1)'(0);
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign txd_o         = txd_q;
    assign busy_o        = busy_q;
    assign fifo_cnt_o    = cnt_q;
    assign wr.wr_ready_o = ready_q;

endmodule

// File: tb/tb_core_uart_tx.sv
// Scoreboard bench for core_uart_tx: pushes record expected frames, a line receiver checks them.
module tb_core_uart_tx;
    localparam int CLK_FREQ_HZ = 1152000;
    localparam int UART_BAUD   = 115200;
    localparam int FIFO_DEPTH  = 16;
    localparam int DIV         = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL     = NB * DIV;
    localparam int M_ANY  = -1;
    localparam int M_CONT = -2;
    localparam int M_LAT  = -3;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       txd_o;
    logic       busy_o;
    logic [4:0] fifo_cnt_o;

    core_uart_tx_if ifc();

    core_uart_tx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .UART_BAUD  (UART_BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr        (ifc),
        .txd_o     (txd_o),
        .busy_o    (busy_o),
        .fifo_cnt_o(fifo_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic samp [FL];
    bit   rx_active  = 1'b0;
    int   rx_off     = 0;
    int   rx_start   = 0;
    int   prev_start = -1000000;

    // Index of the most recent rising edge (posedges at 5, 15, 25, ...)
    function automatic int edge_now();
        return int'(($time - 64'd5) / 64'd10);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_frame();
        logic [7:0] d;
        bit         ok;
        exp_t       e;
        ok = 1'b1;
        for (int b = 0; b < NB; b++) begin
            for (int s = 1; s < DIV; s++) begin
                if (samp[b*DIV+s] !== samp[b*DIV]) ok = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) d[i] = samp[(i+1)*DIV];
        if (samp[0] !== 1'b0) ok = 1'b0;
        if (samp[(NB-1)*DIV] !== 1'b1) ok = 1'b0;
`ifdef UART_TX_PARITY_EN
        if (samp[9*DIV] !== ^d) ok = 1'b0;
`endif
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got 0x%02h expected no frame", d);
        end else begin
            e = exp_q.pop_front();
            if ((d !== e.data) || !ok) begin
                errors++;
                $display("FAIL frame_data: got 0x%02h framing_ok=%0d expected 0x%02h framing_ok=1",
                         d, ok, e.data);
            end
            if (e.start >= 0) begin
                chk("frame_start_edge", rx_start, e.start);
            end else if (e.start == M_CONT) begin
                chk("frame_contiguous", rx_start, prev_start + FL);
            end
        end
        prev_start = rx_start;
    endtask

    // Line receiver: samples txd once per cycle on the falling clock edge
    always @(negedge clk_i) begin
        if (rst_i) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (txd_o === 1'b0) begin
                rx_active = 1'b1;
                rx_off    = 0;
                rx_start  = edge_now();
                samp[0]   = txd_o;
            end
        end else begin
            rx_off++;
            samp[rx_off] = txd_o;
            if (rx_off == FL - 1) begin
                rx_active = 1'b0;
                check_frame();
            end
        end
    end

    // Called on a falling edge; returns the rising edge at which the byte was accepted
    task automatic push(input logic [7:0] b, input int mode, output int pedge);
        exp_t e;
        pedge = -1;
        ifc.wr_valid_i = 1'b1;
        ifc.wr_data_i  = b;
        for (int t = 0; (t < 4000) && (pedge < 0); t++) begin
            if (ifc.wr_ready_o === 1'b1) begin
                @(posedge clk_i);
                pedge   = edge_now();
                e.data  = b;
                e.start = (mode == M_LAT) ? pedge + 1 : mode;
                exp_q.push_back(e);
            end
            @(negedge clk_i);
        end
        ifc.wr_valid_i = 1'b0;
        if (pedge < 0) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no acceptance expected acceptance within 4000 cycles");
        end
    endtask

    task automatic wait_idle(output int fe);
        fe = -1;
        for (int t = 0; (t < 6000) && (fe < 0); t++) begin
            if (busy_o === 1'b0) fe = edge_now();
            else @(negedge clk_i);
        end
        if (fe < 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy expected idle within 6000 cycles");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int tx;
        int fe;
        int lows;
        ifc.wr_valid_i = 1'b0;
        ifc.wr_data_i  = 8'h00;

        #1 rst_i = 1'b1;
        #1;
        chk("reset_txd",   txd_o, 1);
        chk("reset_ready", ifc.wr_ready_o, 1);
        chk("reset_busy",  busy_o, 0);
        chk("reset_cnt",   fifo_cnt_o, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Single byte: start bit at push edge + 1, busy falls one frame later
        push(8'h55, M_LAT, t0);
        wait_idle(fe);
        chk("t1_busy_fall", fe, t0 + 1 + FL);

        // Three bytes pushed in consecutive cycles go out with no gap
        push(8'h48, M_LAT, t0);
        push(8'h69, M_CONT, tx);
        push(8'h0a, M_CONT, tx);
        wait_idle(fe);
        chk("t2_busy_fall", fe, t0 + 1 + 3*FL);

        // Fill the FIFO behind an active frame; one more push waits for the first pop
        push(8'hC5, M_LAT, t0);
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i), M_CONT, tx);
        chk("t3_cnt_full",   fifo_cnt_o, 16);
        chk("t3_ready_full", ifc.wr_ready_o, 0);
        push(8'h40, M_CONT, tx);
        chk("t3_held_push_edge", tx, t0 + 2 + FL);
        wait_idle(fe);
        chk("t3_busy_fall", fe, t0 + 1 + 18*FL);

        // Boundary data patterns
        push(8'h00, M_LAT, t0);
        push(8'hFF, M_CONT, tx);
        push(8'h1b, M_CONT, tx);
        push(8'h04, M_CONT, tx);
        wait_idle(fe);
        chk("t5_busy_fall", fe, t0 + 1 + 4*FL);

`ifdef UART_TX_PARITY_EN
        push(8'h03, M_LAT, t0);
        push(8'h07, M_CONT, tx);
        wait_idle(fe);
        chk("t6_parity_busy_fall", fe, t0 + 1 + 2*FL);
`endif

        // Reset 35 cycles into a frame of 0xA3 with another byte still queued
        push(8'hA3, M_LAT, t0);
        push(8'h5A, M_CONT, tx);
        repeat (35) @(negedge clk_i);
        chk("t4_pre_reset_txd", txd_o, 0);
        chk("t4_pre_reset_cnt", fifo_cnt_o, 1);
        #2 rst_i = 1'b1;
        exp_q.delete();
        #1;
        chk("t4_rst_txd",   txd_o, 1);
        chk("t4_rst_cnt",   fifo_cnt_o, 0);
        chk("t4_rst_busy",  busy_o, 0);
        chk("t4_rst_ready", ifc.wr_ready_o, 1);
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b0;
        lows = 0;
        repeat (200) begin
            @(negedge clk_i);
            if (txd_o !== 1'b1) lows++;
        end
        chk("t4_no_residual_low_cycles", lows, 0);
        chk("t4_after_busy", busy_o, 0);

        // Normal operation resumes after reset
        push(8'h96, M_LAT, t0);
        wait_idle(fe);
        chk("t7_busy_fall", fe, t0 + 1 + FL);

        repeat (5) @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_uart_tx.md
Name: core_uart_tx

Overview:
- Synthesizable 8N1 UART transmitter with byte FIFO. It is the upstream stage that drives the simulation UART monitor's rxd line.
- The core/SoC bus side pushes bytes with a valid/ready handshake. The block serialises them LSB-first on txd_o at UART_BAUD, back-to-back, with no idle gap between frames.

Parameters:
- CLK_FREQ_HZ, 50000000, core clock frequency in Hz.
- UART_BAUD, 115200, bit rate. DIV = CLK_FREQ_HZ / UART_BAUD (integer division) is the clock cycles per bit; DIV >= 2 is required.
- FIFO_DEPTH, 16, byte FIFO entries; must be a power of 2 and >= 2. AW = log2(FIFO_DEPTH).

Ports:
- clk_i  input  1  core clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- wr_valid_i  input  1  byte push request.
- wr_data_i  input  8  byte to send.
- wr_ready_o  output  1  FIFO can accept; equals !full.
- txd_o  output  1  serial line, idle high, registered.
- busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_cnt_o  output  AW+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (async, rst_i=1):
  - txd_o=1, wr_ready_o=1, busy_o=0, fifo_cnt_o=0.
  - FIFO pointers cleared, state IDLE, baud and bit counters 0.
  - Asserting reset mid-frame truncates the frame; the line returns high immediately and FIFO contents are discarded.
- Push:
  - A push happens at an edge with wr_valid_i && wr_ready_o. The byte is written at the write pointer and fifo_cnt_o increments at that edge.
  - When full (cnt==FIFO_DEPTH), wr_ready_o=0 and pushes stall, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- Baud counter:
  - Counts 0..DIV-1 while not IDLE. Bit tick = (cnt==DIV-1).
  - The counter is cleared on entering START.
  - Each bit is held for exactly DIV cycles.
- FSM states and transitions:
  - IDLE: txd_o=1. If FIFO non-empty, at the next edge pop the head into an 8-bit shift register and go to START.
  - START: txd_o=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: txd_o = shift[0]. On each tick, shift right and increment the index. After the tick with index 7, go to STOP, or to PARITY when UART_TX_PARITY_EN is defined.
  - STOP: txd_o=1 for DIV cycles. On the tick:
    - if FIFO non-empty, pop and go directly to START (no gap);
    - else go to IDLE.
- Latency: a byte pushed at edge T into an empty, idle block pops at edge T+1, and txd_o falls from T+1.
- Frame timing:
  - Frame length is 10*DIV cycles (11*DIV with parity).
  - Back-to-back frames are contiguous: the stop bit ends and the next start bit begins at the same edge.
- Wrap-around: read/write pointers are AW bits and wrap naturally. The count is tracked separately, so full and empty are unambiguous.
- busy_o = (state != IDLE) || (fifo_cnt_o != 0), registered-equivalent: it falls exactly when STOP→IDLE occurs with an empty FIFO.
- Glitch-free output: txd_o comes straight from a flop and never glitches.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - an even-parity bit (XOR of the 8 data bits, latched at pop) is sent in a PARITY state between DATA and STOP;
  - the frame is 11*DIV cycles.
- When undefined: there is no PARITY state and the frame is 8N1 at 10*DIV cycles. The monitor only accepts 8N1, so this macro is left undefined in monitor-based benches.

Test Plan:
1. CLK_FREQ_HZ=1152000, UART_BAUD=115200 (DIV=10); push 0x55 at edge T -> txd_o low from T+1 to T+11, then bits 1,0,1,0,1,0,1,0 of 10 cycles each, stop high; busy_o falls at T+101.
2. Push 'H','i',0x0a in consecutive cycles -> three contiguous frames of 300 cycles total with no idle gap; the monitor prints "UART: Hi".
3. Push 17 bytes while the line is busy -> fifo_cnt_o reaches 16, wr_ready_o=0, and the 17th push is held until the first pop, then accepted.
4. Assert rst_i 35 cycles into a frame of 0xA3 -> txd_o=1 immediately, fifo_cnt_o=0; after release, no residual frame is transmitted.
5. With UART_TX_PARITY_EN: send 0x03 -> parity bit 0; send 0x07 -> parity bit 1; each frame is 110 cycles.
6. Push 0x1b then 0x04 -> the monitor enters debug mode and ends the simulation.
